vga_scan_reader: RTL and testbench
==================================

VGA_SCAN_READER -- requirements
Module: vga_scan_reader

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, reset; no other clock or reset input exists.
REQ-002 Parameters SHALL be:
- IMG_W, 256, image width in pixels (power of two).
- IMG_H, 256, image height in lines.
- ADDR_W, 17, pixel memory address width: 1 buffer bit + 8 y bits + 8 x bits.
REQ-003 Ports SHALL be:
- clk  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-high.
- swap_req  in  1  level request to flip the display buffer.
- swap_ack  out  1  one-clk pulse when the flip occurs.
- mem_addr  out  ADDR_W  pixel memory read address.
- mem_rdata  in  8  pixel byte, valid one clk after mem_addr.
- frame_start  out  1  one-clk pulse at counter wrap to (0,0).
- hsync, vsync  out  1  active-low syncs.
- blank  out  1  DAC BLANK_N; 1 = visible.
- sync  out  1  DAC SYNC_N, constant 0.
- r, g, b  out  8  colour.
- vga_clk  out  1  pixel clock, clk/2.

Function
REQ-004 vga_clk SHALL toggle every clk; a pixel tick SHALL be the clk in which vga_clk goes 0->1, giving 25 MHz.
REQ-005 On each pixel tick, h SHALL count 0..799 and wrap to 0; v SHALL increment when h wraps, count 0..524, and wrap to 0.
REQ-006 Visible SHALL be h<640 and v<480. hsync SHALL be 0 for h in 656..751. vsync SHALL be 0 for v in 490..491.
REQ-007 In-image SHALL be h<IMG_W and v<IMG_H; mem_addr SHALL be {active_buf, v[7:0], h[7:0]}, registered on the pixel tick.
REQ-008 When not in-image, mem_addr SHALL hold its last value.
REQ-009 mem_rdata SHALL be captured one clk after mem_addr updates.
REQ-010 hsync, vsync and blank SHALL be delayed through the same pipeline so that all pins align; the latency from counter value to pins is fixed at 2 pixel ticks.
REQ-011 Pixels that are visible but not in-image SHALL drive r=g=b=0. Non-visible pixels SHALL drive r=g=b=0 with blank=0.
REQ-012 frame_start SHALL pulse for one clk on the tick where (h,v) goes from (799,524) to (0,0).
REQ-013 If swap_req=1 on that same wrap tick, active_buf SHALL toggle and swap_ack SHALL pulse in the same clk as frame_start.
REQ-014 swap_req=0 at the wrap tick SHALL leave active_buf unchanged.
REQ-015 swap_req held high across several frames SHALL toggle active_buf at every wrap; the requester drops swap_req after swap_ack.
REQ-016 swap_req asserting mid-frame SHALL NOT change mem_addr until the next wrap; a buffer never changes within a frame.

Reset
REQ-017 Reset values SHALL be: h=0, v=0, vga_clk=0, active_buf=0, mem_addr=0, hsync=1, vsync=1, blank=0, sync=0, r=g=b=0, swap_ack=0, frame_start=0, pipeline cleared.
REQ-018 Reset mid-frame SHALL restart at (0,0) and discard any pending swap_req without issuing swap_ack.
REQ-019 The first pixel tick after reset SHALL occur on the second clk after reset deasserts.

Configuration
REQ-020 With VGA_GRAYSCALE_EN defined, r, g and b SHALL each equal mem_rdata.
REQ-021 Without VGA_GRAYSCALE_EN, mem_rdata SHALL be decoded as RGB332:
- r = {d[7:5], d[7:5], d[7:6]}
- g = {d[4:2], d[4:2], d[4:3]}
- b = {d[1:0], d[1:0], d[1:0], d[1:0]}

Structure
REQ-022 Package vga_pkg SHALL hold the timing constants H_VISIBLE=640, H_FRONT=16, H_SYNC=96, H_TOTAL=800, V_VISIBLE=480, V_FRONT=10, V_SYNC=2, V_TOTAL=525, and the hv_t typedef (10-bit h, 10-bit v).
REQ-023 Sub-module vga_timing SHALL contain the pixel divider and the h/v counters, and output pixel tick, h, v, visible and the raw syncs.
REQ-024 The rest of the block (address generation, buffer flip, data pipeline, colour decode) SHALL reside in vga_scan_reader.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset 3 clks, then run one frame -> frame_start every 840000 clks; hsync low for 192 clks per line; vsync low for 2 lines.
- mem model returns data = addr[7:0], GRAYSCALE on -> visible pixel h=5, v=0 shows r=g=b=5 two ticks later; h=300 shows 0 with blank=1.
- Memory always returns 8'hE3, GRAYSCALE off -> r=FF, g=00, b=FF during the in-image area.
- swap_req raised at v=100 -> mem_addr[16] stays 0 until wrap, then 1; swap_ack coincides with frame_start; swap_req dropped -> stays 1.
- Reset at h=400, v=200 with swap_req=1 -> next clk has all outputs at reset values, swap_ack never pulses, active_buf=0.
- v=255 to v=256 -> mem_addr frozen and r=g=b=0 for v=256..479 while blank=1 for h<640.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants and shared types for the scan reader
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_TOTAL   = 525;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
    } hv_t;

    // RGB332 byte widened to 8:8:8 by replicating the MSBs into the low bits
    function automatic logic [23:0] rgb332_expand(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6],
                d[4:2], d[4:2], d[4:3],
                d[1:0], d[1:0], d[1:0], d[1:0]};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - clk/2 pixel divider and h/v raster counters with raw syncs
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic       vga_clk,
    output logic       tick,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       visible,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       wrap
);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic vga_clk_q;
    hv_t  pos_q;
    hv_t  pos_d;

    always_comb begin
        pos_d = pos_q;
        if (pos_q.h == H_LAST) begin
            pos_d.h = 10'd0;
            pos_d.v = (pos_q.v == V_LAST) ? 10'd0 : pos_q.v + 10'd1;
        end else begin
            pos_d.h = pos_q.h + 10'd1;
        end
    end

    // The tick is the half-period where vga_clk is high; counters advance as it falls
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_clk_q <= 1'b0;
            pos_q     <= '0;
        end else begin
            vga_clk_q <= ~vga_clk_q;
            if (vga_clk_q) begin
                pos_q <= pos_d;
            end
        end
    end

    assign vga_clk   = vga_clk_q;
    assign tick      = vga_clk_q;
    assign h         = pos_q.h;
    assign v         = pos_q.v;
    assign visible   = (pos_q.h < 10'(H_VISIBLE)) && (pos_q.v < 10'(V_VISIBLE));
    assign hsync_raw = !((pos_q.h >= HS_START) && (pos_q.h < HS_END));
    assign vsync_raw = !((pos_q.v >= VS_START) && (pos_q.v < VS_END));
    assign wrap      = vga_clk_q && (pos_q.h == H_LAST) && (pos_q.v == V_LAST);

endmodule

// File: rtl/vga_scan_reader.sv
// rtl/vga_scan_reader.sv - double-buffered pixel fetch and VGA DAC drive; VGA_GRAYSCALE_EN selects grey output
module vga_scan_reader
    import vga_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              frame_start,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              sync,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              vga_clk
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = ADDR_W - 1 - XW;

    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       visible;
    logic       hsync_raw;
    logic       vsync_raw;
    logic       wrap;

    vga_timing u_timing (
        .clk       (clk),
        .reset     (reset),
        .vga_clk   (vga_clk),
        .tick      (tick),
        .h         (h),
        .v         (v),
        .visible   (visible),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .wrap      (wrap)
    );

    logic              in_image;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [23:0]       pix_d;

    logic              active_buf_q;
    logic              swap_ack_q;
    logic              frame_start_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              vis_s1_q;
    logic              img_s1_q;
    logic              hs_s1_q;
    logic              vs_s1_q;
    logic              hsync_q;
    logic              vsync_q;
    logic              blank_q;
    logic [23:0]       pix_q;

    assign in_image   = (h < 10'(IMG_W)) && (v < 10'(IMG_H));
    assign mem_addr_d = {active_buf_q, v[YW-1:0], h[XW-1:0]};

    always_comb begin
        pix_d = 24'h0;
        if (img_s1_q) begin
`ifdef VGA_GRAYSCALE_EN
            pix_d = {mem_rdata, mem_rdata, mem_rdata};
`else
            pix_d = rgb332_expand(mem_rdata);
`endif
        end
    end

    // Stage 1 issues the address and parks the sync/visibility flags while the
    // memory answers; stage 2 lands colour and syncs on the pins together.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_buf_q  <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            mem_addr_q    <= '0;
            vis_s1_q      <= 1'b0;
            img_s1_q      <= 1'b0;
            hs_s1_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_q       <= 1'b0;
            pix_q         <= 24'h0;
        end else begin
            frame_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            if (tick) begin
                if (in_image) begin
                    mem_addr_q <= mem_addr_d;
                end
                vis_s1_q <= visible;
                img_s1_q <= in_image;
                hs_s1_q  <= hsync_raw;
                vs_s1_q  <= vsync_raw;
                blank_q  <= vis_s1_q;
                hsync_q  <= hs_s1_q;
                vsync_q  <= vs_s1_q;
                pix_q    <= pix_d;
            end
            // Flip only at the raster wrap so a frame never mixes buffers
            if (wrap) begin
                frame_start_q <= 1'b1;
                if (swap_req) begin
                    active_buf_q <= ~active_buf_q;
                    swap_ack_q   <= 1'b1;
                end
            end
        end
    end

    assign swap_ack    = swap_ack_q;
    assign frame_start = frame_start_q;
    assign mem_addr    = mem_addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign sync        = 1'b0;
    assign r           = pix_q[23:16];
    assign g           = pix_q[15:8];
    assign b           = pix_q[7:0];

endmodule

// File: tb/tb_vga_scan_reader.sv
// tb/tb_vga_scan_reader.sv - raster scoreboard plus directed reset, pixel, swap and freeze scenarios
module tb_vga_scan_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic [16:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        sync;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        vga_clk;

    vga_scan_reader dut (
        .clk         (clk),
        .reset       (reset),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .sync        (sync),
        .r           (r),
        .g           (g),
        .b           (b),
        .vga_clk     (vga_clk)
    );

    always #10 clk = ~clk;

    int   checks = 0;
    int   fails  = 0;
    logic mem_mode = 1'b0;

    // Synchronous pixel memory: either echoes the x byte or returns a fixed colour
    always @(posedge clk) mem_rdata <= mem_mode ? 8'hE3 : mem_addr[7:0];

    function automatic logic [23:0] expect_rgb(input logic [7:0] d);
`ifdef VGA_GRAYSCALE_EN
        return {d, d, d};
`else
        logic [7:0] er, eg, eb;
        er = {d[7:5], d[7:5], d[7:6]};
        eg = {d[4:2], d[4:2], d[4:3]};
        eb = {d[1:0], d[1:0], d[1:0], d[1:0]};
        return {er, eg, eb};
`endif
    endfunction

    // Reference raster: n counts clocks since reset release, even n are pixel ticks
    int          n = 0;
    int          mh = 0;
    int          mv = 0;
    logic        mbuf = 1'b0;
    logic [16:0] e_addr = '0;
    logic        e_fs = 1'b0;
    logic        e_ack = 1'b0;
    logic [26:0] e_pins = {3'b110, 24'h0};
    logic [26:0] pq[$];
    logic        m_vis, m_img;
    logic [7:0]  m_data;
    logic [46:0] got_v, exp_v;

    always @(posedge clk) begin
        if (reset) begin
            n = 0; mh = 0; mv = 0; mbuf = 1'b0; e_addr = '0;
            e_fs = 1'b0; e_ack = 1'b0; e_pins = {3'b110, 24'h0};
            pq.delete();
        end else begin
            n++;
            e_fs = 1'b0;
            e_ack = 1'b0;
            if (n % 2 == 0) begin
                if (pq.size() > 0) e_pins = pq.pop_front();
                m_vis = (mh < 640) && (mv < 480);
                m_img = (mh < 256) && (mv < 256);
                if (m_img) e_addr = {mbuf, 8'(mv), 8'(mh)};
                m_data = mem_mode ? 8'hE3 : e_addr[7:0];
                pq.push_back({!(mh >= 656 && mh < 752), !(mv >= 490 && mv < 492), m_vis,
                              m_img ? expect_rgb(m_data) : 24'h0});
                mh++;
                if (mh == 800) begin
                    mh = 0;
                    mv++;
                    if (mv == 525) begin
                        mv = 0;
                        e_fs = 1'b1;
                        if (swap_req) begin
                            mbuf = ~mbuf;
                            e_ack = 1'b1;
                        end
                    end
                end
            end
        end
        #1;
        got_v = {frame_start, swap_ack, mem_addr, hsync, vsync, blank, r, g, b, sync, vga_clk};
        exp_v = {e_fs, e_ack, e_addr, e_pins, 1'b0, 1'((n % 2) == 1)};
        checks++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL scoreboard n=%0d got=%h expected=%h", n, got_v, exp_v);
            if (fails >= 100) begin
                $display("FAIL too_many_failures");
                $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
                $finish;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        swap_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({hsync, vsync, blank, sync} !== 4'b1100) begin
            fails++; $display("FAIL reset_syncs got=%b expected=1100", {hsync, vsync, blank, sync});
        end
        checks++;
        if ({r, g, b} !== 24'h0) begin
            fails++; $display("FAIL reset_rgb got=%h expected=000000", {r, g, b});
        end
        checks++;
        if ({frame_start, swap_ack, vga_clk, mem_addr} !== 20'h0) begin
            fails++; $display("FAIL reset_misc got=%h expected=0", {frame_start, swap_ack, vga_clk, mem_addr});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (vga_clk !== 1'b1) begin
            fails++; $display("FAIL first_vga_clk got=%b expected=1", vga_clk);
        end
    endtask

    task automatic test_frame();
        int  hs_low = 0;
        int  vs_low = 0;
        int  fs_at = -1;
        bit  raised = 0;
        bit  moded = 0;
        for (int i = 0; i < 900000; i++) begin
            @(negedge clk);
            if (n >= 3200 && n < 4800 && hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (n == 14) begin
                checks++;
                if ({blank, r, g, b} !== {1'b1, expect_rgb(8'd5)}) begin
                    fails++; $display("FAIL pix_h5 got=%h expected=%h", {blank, r, g, b}, {1'b1, expect_rgb(8'd5)});
                end
            end
            if (n == 604) begin
                checks++;
                if ({blank, r, g, b} !== {1'b1, 24'h0}) begin
                    fails++; $display("FAIL pix_h300 got=%h expected=1000000", {blank, r, g, b});
                end
            end
            if (!raised && mv == 100) begin
                swap_req = 1'b1;
                raised = 1;
            end
            if (mv == 255 && mh == 100 && n % 2 == 1) begin
                checks++;
                if (mem_addr[16] !== 1'b0) begin
                    fails++; $display("FAIL buf_before_wrap got=%b expected=0", mem_addr[16]);
                end
            end
            if (mv == 300 && mh == 100 && n % 2 == 1) begin
                checks++;
                if ({mem_addr, blank, r, g, b} !== {17'h0FFFF, 1'b1, 24'h0}) begin
                    fails++; $display("FAIL addr_frozen got=%h expected=%h", {mem_addr, blank, r, g, b}, {17'h0FFFF, 1'b1, 24'h0});
                end
            end
            if (!moded && mv == 500) begin
                mem_mode = 1'b1;
                moded = 1;
            end
            if (frame_start === 1'b1) begin
                fs_at = n;
                checks++;
                if (swap_ack !== 1'b1) begin
                    fails++; $display("FAIL ack_with_fs got=%b expected=1", swap_ack);
                end
                break;
            end
        end
        swap_req = 1'b0;
        checks++;
        if (fs_at != 840000) begin
            fails++; $display("FAIL frame_period got=%0d expected=840000", fs_at);
        end
        checks++;
        if (hs_low != 192) begin
            fails++; $display("FAIL hsync_width got=%0d expected=192", hs_low);
        end
        checks++;
        if (vs_low != 3200) begin
            fails++; $display("FAIL vsync_width got=%0d expected=3200", vs_low);
        end
    endtask

    task automatic test_rgb_after_swap();
        bit seen = 0;
        for (int i = 0; i < 400000 && !seen; i++) begin
            @(negedge clk);
            if (mv == 10 && mh == 20 && n % 2 == 1) begin
                seen = 1;
                checks++;
                if ({r, g, b} !== expect_rgb(8'hE3)) begin
                    fails++; $display("FAIL rgb_e3 got=%h expected=%h", {r, g, b}, expect_rgb(8'hE3));
                end
                checks++;
                if (mem_addr[16] !== 1'b1) begin
                    fails++; $display("FAIL buf_after_wrap got=%b expected=1", mem_addr[16]);
                end
            end
        end
        checks++;
        if (!seen) begin
            fails++; $display("FAIL rgb_e3_timeout got=0 expected=1");
        end
    endtask

    task automatic test_reset_midframe();
        bit reached = 0;
        int acks = 0;
        for (int i = 0; i < 400000 && !reached; i++) begin
            @(negedge clk);
            if (mv == 200 && mh == 400) reached = 1;
        end
        checks++;
        if (!reached) begin
            fails++; $display("FAIL midframe_timeout got=0 expected=1");
        end
        checks++;
        if (mem_addr[16] !== 1'b1) begin
            fails++; $display("FAIL buf_held got=%b expected=1", mem_addr[16]);
        end
        reset = 1'b1;
        swap_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({frame_start, swap_ack, mem_addr, hsync, vsync, blank, sync, r, g, b, vga_clk} !==
            {2'b00, 17'h0, 4'b1100, 24'h0, 1'b0}) begin
            fails++; $display("FAIL midframe_reset got=%h expected=%h",
                {frame_start, swap_ack, mem_addr, hsync, vsync, blank, sync, r, g, b, vga_clk},
                {2'b00, 17'h0, 4'b1100, 24'h0, 1'b0});
        end
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (swap_ack === 1'b1) acks++;
            if (n == 101) begin
                checks++;
                if (mem_addr[16] !== 1'b0) begin
                    fails++; $display("FAIL buf_after_reset got=%b expected=0", mem_addr[16]);
                end
            end
        end
        swap_req = 1'b0;
        checks++;
        if (acks != 0) begin
            fails++; $display("FAIL no_ack_after_reset got=%0d expected=0", acks);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_rgb_after_swap();
        test_reset_midframe();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
